// File: rtl/vga_pkg.sv
// Shared constants and state type for the VGA plot arbiter.
package vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned NUM_ENG  = 3;
  localparam logic [15:0] WDOG_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } arb_state_e;

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters, starting after 'last'.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] c0, c1, c2;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    c0    = next_idx(last);
    c1    = next_idx(c0);
    c2    = next_idx(c1);
    valid = |req;
    if (req[c0])      idx = c0;
    else if (req[c1]) idx = c1;
    else if (req[c2]) idx = c2;
    else              idx = 2'd0;
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Arbitrates three drawing engines onto one VGA adapter port with a
// start/done handshake, pixel clipping and a RUN-state watchdog.
module vga_plot_arbiter
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  output logic [2:0]  grant,
  output logic [2:0]  eng_start,
  input  logic [2:0]  eng_done,
  input  logic [23:0] eng_x,
  input  logic [20:0] eng_y,
  input  logic [8:0]  eng_colour,
  input  logic [2:0]  eng_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        wdog_err
);

  localparam logic [7:0] ScreenWx = 8'(SCREEN_W);
  localparam logic [6:0] ScreenHy = 7'(SCREEN_H);

  arb_state_e  state_q, state_d;
  logic [1:0]  owner_q, owner_d, last_q, last_d;
  logic [15:0] wdog_q, wdog_d, wdog_inc;
  logic [2:0]  grant_q, grant_d, start_q, start_d;
  logic        err_q, err_d, busy_q, plot_q, plot_d;
  logic [7:0]  x_q, x_d, own_x;
  logic [6:0]  y_q, y_d, own_y;
  logic [2:0]  col_q, col_d, own_col;
  logic        own_done, own_plot;
  logic        pick_valid;
  logic [1:0]  pick_idx;

  rr_pick3 u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Only the owner's lanes are ever looked at.
  always_comb begin
    case (owner_q)
      2'd1: begin
        own_done = eng_done[1]; own_plot = eng_plot[1];
        own_x = eng_x[15:8]; own_y = eng_y[13:7]; own_col = eng_colour[5:3];
      end
      2'd2: begin
        own_done = eng_done[2]; own_plot = eng_plot[2];
        own_x = eng_x[23:16]; own_y = eng_y[20:14]; own_col = eng_colour[8:6];
      end
      default: begin
        own_done = eng_done[0]; own_plot = eng_plot[0];
        own_x = eng_x[7:0]; own_y = eng_y[6:0]; own_col = eng_colour[2:0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wdog_d   = wdog_q;
    grant_d  = grant_q;
    start_d  = start_q;
    err_d    = 1'b0;
    wdog_inc = wdog_q + 16'd1;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          grant_d = idx_to_onehot(pick_idx);
          start_d = idx_to_onehot(pick_idx);
          wdog_d  = 16'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        wdog_d = wdog_inc;
        if (own_done) begin
          start_d = 3'b000;
          last_d  = owner_q;
          state_d = StDrain;
        end else if (wdog_inc == WDOG_MAX) begin
          err_d   = 1'b1;
          start_d = 3'b000;
          last_d  = owner_q;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!own_done) begin
          grant_d = 3'b000;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pixel path; a plot on the exiting RUN cycle is dropped so DRAIN stays quiet.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    col_d  = col_q;
    plot_d = 1'b0;
    if (state_q == StRun) begin
      x_d    = own_x;
      y_d    = own_y;
      col_d  = own_col;
      plot_d = (state_d == StRun) && own_plot && (own_x < ScreenWx) && (own_y < ScreenHy);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      wdog_q  <= 16'd0;
      grant_q <= 3'b000;
      start_q <= 3'b000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      plot_q  <= 1'b0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      col_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      grant_q <= grant_d;
      start_q <= start_d;
      err_q   <= err_d;
      busy_q  <= (state_d != StIdle);
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
    end
  end

  assign grant      = grant_q;
  assign eng_start  = start_q;
  assign wdog_err   = err_q;
  assign busy       = busy_q;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: handshake, fairness, clipping, reset, watchdog.
module tb_vga_plot_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, grant, eng_start, eng_done, eng_plot;
  logic [23:0] eng_x;
  logic [20:0] eng_y;
  logic [8:0]  eng_colour;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, wdog_err;

  int total = 0;
  int bad   = 0;
  int pulses;
  logic [2:0] exp_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  always #5 clk = ~clk;

  vga_plot_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_colour (eng_colour),
    .eng_plot   (eng_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .wdog_err   (wdog_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; eng_done = '0; eng_plot = '0;
    eng_x = '0; eng_y = '0; eng_colour = '0;
    #2;
    check("rst_grant", grant, 3'b000);
    check("rst_start", eng_start, 3'b000);
    check("rst_outs", {vga_plot, busy, wdog_err, vga_x, vga_y, vga_colour}, 0);
    do_reset();
    tick();
    check("idle_grant", grant, 3'b000);
    check("idle_busy", busy, 1'b0);

    // Single requester
    req = 3'b001;
    tick();
    check("s_grant", grant, 3'b001);
    check("s_start", eng_start, 3'b001);
    check("s_busy", busy, 1'b1);
    eng_plot = 3'b001; eng_x = {16'd0, 8'd5}; eng_y = {14'd0, 7'd7}; eng_colour = {6'd0, 3'd3};
    tick();
    check("s_pix", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, 8'd5, 7'd7, 3'd3});
    eng_plot = 3'b000; eng_done = 3'b001;
    tick();
    check("s_done_start", eng_start, 3'b000);
    check("s_drain_grant", grant, 3'b001);
    check("s_drain_plot", vga_plot, 1'b0);
    eng_done = 3'b000; req = 3'b000;
    tick();
    check("s_release", grant, 3'b000);
    check("s_idle_busy", busy, 1'b0);

    // Contention fairness from reset
    do_reset();
    req = 3'b111;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("rr_grant", grant, exp_order[j]);
      eng_done = exp_order[j];
      tick();
      check("rr_drain_start", eng_start, 3'b000);
      eng_done = 3'b000;
      if (j == 3) req = 3'b000;
      tick();
      check("rr_idle", grant, 3'b000);
    end

    // Clipping and non-owner noise, engine 0 owns
    req = 3'b001;
    tick();
    check("c_grant", grant, 3'b001);
    eng_plot = 3'b001; eng_x = {16'd0, 8'd160}; eng_y = {14'd0, 7'd0};
    tick();
    check("c_x160", {vga_plot, vga_x}, {1'b0, 8'd160});
    eng_x = {16'd0, 8'd0}; eng_y = {14'd0, 7'd120};
    tick();
    check("c_y120", {vga_plot, vga_y}, {1'b0, 7'd120});
    eng_x = {16'd0, 8'd159}; eng_y = {14'd0, 7'd119};
    tick();
    check("c_edge", {vga_plot, vga_x, vga_y}, {1'b1, 8'd159, 7'd119});
    eng_plot = 3'b100; eng_done = 3'b100;
    eng_x = {8'd10, 8'd0, 8'd159}; eng_y = {7'd10, 7'd0, 7'd119};
    tick();
    check("n_plot", {vga_plot, vga_x}, {1'b0, 8'd159});
    check("n_state", {grant, eng_start, busy}, {3'b001, 3'b001, 1'b1});
    eng_plot = 3'b001; eng_done = 3'b000; eng_x = {8'd200, 8'd0, 8'd1}; eng_y = {7'd3, 7'd0, 7'd2};
    tick();
    check("n_owner_pix", {vga_plot, vga_x, vga_y}, {1'b1, 8'd1, 7'd2});
    eng_plot = 3'b000; eng_done = 3'b001; req = 3'b000;
    tick();
    eng_done = 3'b000;
    tick();
    check("c_idle", grant, 3'b000);

    // Reset mid-RUN with engine 1 owning
    req = 3'b010;
    tick();
    check("r_grant", grant, 3'b010);
    eng_plot = 3'b010; eng_x = {8'd0, 8'd20, 8'd0}; eng_y = {7'd0, 7'd30, 7'd0};
    tick();
    check("r_plot", vga_plot, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("r_async", {grant, eng_start, vga_plot}, {3'b000, 3'b000, 1'b0});
    eng_plot = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("r_regrant", grant, 3'b010);
    eng_done = 3'b010; req = 3'b000;
    tick();
    eng_done = 3'b000;
    tick();
    check("r_idle", grant, 3'b000);

    // Watchdog: engine 0 never finishes
    req = 3'b001;
    tick();
    check("w_grant", grant, 3'b001);
    req = 3'b000;
    pulses = 0;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
      #1;
      if (wdog_err) pulses++;
    end
    check("w_early", pulses, 0);
    check("w_still_run", eng_start, 3'b001);
    tick();
    check("w_pulse", {wdog_err, eng_start, grant}, {1'b1, 3'b000, 3'b001});
    eng_done = 3'b001;
    tick();
    check("w_once", wdog_err, 1'b0);
    check("w_drain", {grant, busy}, {3'b001, 1'b1});
    tick();
    check("w_drain_hold", grant, 3'b001);
    eng_done = 3'b000;
    tick();
    check("w_idle", {grant, busy, wdog_err}, {3'b000, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
